// File: rtl/chi_pkg.sv
// Shared CHI definitions: link states, REQ flit layout and L-credit limits.
// The REQ flit layout mirrors chi_flit.vh so the channel blocks build without include paths.
package chi_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    ACT   = 2'd1,
    RUN   = 2'd2,
    DEACT = 2'd3
  } chi_link_e;

  localparam int         MAX_LCRD       = 15;
  localparam logic [6:0] REQ_LCRDRETURN = 7'h00;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [6:0]  opcode;
    logic [23:0] addr;
  } reqflit_t;

endpackage

// File: rtl/chi_hn_req_intf.sv
// CHI REQ channel link: flit, flitv and flitpend flow TX->RX, lcrdv flows RX->TX.
interface chi_hn_req_intf;
  import chi_pkg::*;

  logic     flitpend;
  logic     flitv;
  reqflit_t flit;
  logic     lcrdv;

  modport TX (output flitpend, output flitv, output flit, input lcrdv);
  modport RX (input flitpend, input flitv, input flit, output lcrdv);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  int idx;

  // Scan from furthest to nearest so the nearest requester after ptr overwrites the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt          = '0;
        gnt[idx]     = 1'b1;
        gnt_idx      = ($clog2(N))'(idx);
      end
    end
  end

endmodule

// File: rtl/chi_req_tx_sched.sv
// CHI REQ TX scheduler: round-robin requester arbitration, L-credit accounting,
// TXLINKACTIVE handshake and LCrdReturn flushing during link deactivation.
module chi_req_tx_sched
  import chi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_CRD = MAX_LCRD,
  parameter int CRD_W   = $clog2(MAX_CRD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    link_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  reqflit_t [NUM_REQ-1:0]  req_flit,
  output logic [NUM_REQ-1:0]      req_ready,
  chi_hn_req_intf.TX              tx,
  output logic                    txlinkactivereq,
  input  logic                    txlinkactiveack,
  output logic [1:0]              link_state,
  output logic [CRD_W-1:0]        crd_cnt,
  output logic                    crd_err
);

  localparam int IW = $clog2(NUM_REQ);

  chi_link_e        state;
  logic             pend_q;
  logic             pend_d;
  logic             flitv_q;
  reqflit_t         flit_q;
  reqflit_t         ret_flit;
  logic [IW-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             can_send;
  logic             xfer;
  logic             lcrd_ret;
  logic             send;
  logic             crd_in;
  logic [CRD_W-1:0] crd_left;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign can_send  = (crd_cnt != '0) && pend_q;
  assign req_ready = (state == RUN && can_send) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign lcrd_ret  = (state == DEACT) && can_send;
  assign send      = xfer | lcrd_ret;
  assign crd_in    = tx.lcrdv && (state != STOP);
  assign crd_left  = crd_cnt - CRD_W'(send);
  assign pend_d    = (state == RUN && |req_valid) || (state == DEACT && crd_left != '0);

  assign link_state  = state;
  assign tx.flitpend = pend_q;
  assign tx.flitv    = flitv_q;
  assign tx.flit     = flit_q;

  always_comb begin
    ret_flit        = '0;
    ret_flit.opcode = REQ_LCRDRETURN;
  end

  // Link FSM; an ack seen in ACT wins over a simultaneous link_en drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= STOP;
      txlinkactivereq <= 1'b0;
    end else begin
      case (state)
        STOP: if (link_en) begin
          state           <= ACT;
          txlinkactivereq <= 1'b1;
        end
        ACT: if (txlinkactiveack) begin
          state <= RUN;
        end else if (!link_en) begin
          state           <= STOP;
          txlinkactivereq <= 1'b0;
        end
        RUN: if (!link_en) begin
          state           <= DEACT;
          txlinkactivereq <= 1'b0;
        end
        DEACT: if (crd_cnt == '0 && !txlinkactiveack) begin
          state <= STOP;
        end
        default: state <= STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      flitv_q <= 1'b0;
      flit_q  <= '0;
      rr_ptr  <= '0;
      crd_cnt <= '0;
      crd_err <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      flitv_q <= send;
      if (xfer) begin
        flit_q <= req_flit[gnt_idx];
        rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (lcrd_ret) begin
        flit_q <= ret_flit;
      end
      if (tx.lcrdv && state == STOP) begin
        crd_err <= 1'b1;
      end
      // A credit in and a flit out in the same cycle cancel out.
      if (crd_in && !send) begin
        if (crd_cnt == CRD_W'(MAX_CRD)) begin
          crd_err <= 1'b1;
        end else begin
          crd_cnt <= crd_cnt + 1'b1;
        end
      end else if (!crd_in && send) begin
        crd_cnt <= crd_cnt - 1'b1;
      end
    end
  end

endmodule
